// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding and default datapath width for the ALU stages
package alu_pkg;
    localparam int ALU_WIDTH = 32;
    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_NOR = 3'd3
    } op_e;
endpackage

// File: rtl/alu_bitwise_stage_if.sv
// alu_bitwise_stage_if: request/result handshake bundle of the bitwise ALU stage
interface alu_bitwise_stage_if import alu_pkg::*; #(parameter int WIDTH = ALU_WIDTH);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_1;
    logic [WIDTH-1:0] i_2;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o;
    logic             o_zero;
    logic             o_neg;
    logic             o_err;
    logic [15:0]      o_count;
    modport slave (
        input  i_valid, i_op, i_1, i_2, i_ready,
        output o_ready, o_valid, o, o_zero, o_neg, o_err, o_count
    );
    modport master (
        output i_valid, i_op, i_1, i_2, i_ready,
        input  o_ready, o_valid, o, o_zero, o_neg, o_err, o_count
    );
endinterface

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: DEPTH-entry result FIFO; head reads zero while empty
module alu_res_fifo #(parameter int W = 35, parameter int DEPTH = 2) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_wr, do_rd;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = empty ? '0 : mem[rp];
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (do_rd) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end
endmodule

// File: rtl/or_bitwise.sv
// or_bitwise: bitwise OR of two operands
module or_bitwise #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a | b;
endmodule

// File: rtl/alu_bitwise_stage.sv
// alu_bitwise_stage: AND/OR/XOR/NOR stage with flagged results queued in a FIFO
module alu_bitwise_stage import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    alu_bitwise_stage_if.slave bus
);
    logic [WIDTH-1:0] or_y, res;
    logic [WIDTH+2:0] din, dout;
    logic             full, empty, accept, err;
    or_bitwise #(.WIDTH(WIDTH)) u_or (.a(bus.i_1), .b(bus.i_2), .y(or_y));
    assign err = bus.i_op[2];
    always_comb res = bus.i_op == OP_AND ? bus.i_1 & bus.i_2 :
                      bus.i_op == OP_OR  ? or_y :
                      bus.i_op == OP_XOR ? bus.i_1 ^ bus.i_2 :
                      bus.i_op == OP_NOR ? ~or_y : '0;
    // flags are stored alongside the result so the head drives everything from state
    assign din    = {err, res == '0, res[WIDTH-1], res};
    assign accept = bus.i_valid && !full;
    alu_res_fifo #(.W(WIDTH + 3), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .wr(bus.i_valid), .din(din), .rd(bus.i_ready),
        .dout(dout), .full(full), .empty(empty)
    );
    assign {bus.o_err, bus.o_zero, bus.o_neg, bus.o} = dout;
    assign bus.o_valid = !empty;
    assign bus.o_ready = !full;
    always_ff @(posedge clk) begin
        if (rst) bus.o_count <= '0;
        else if (accept) bus.o_count <= bus.o_count + 16'd1;
    end
endmodule

// File: tb/tb_alu_bitwise_stage.sv
// tb_alu_bitwise_stage: directed plus random checks of alu_bitwise_stage against a queue model
module tb_alu_bitwise_stage;
    localparam int W = 32;
    localparam int D = 2;
    typedef struct {
        logic [W-1:0] r;
        logic z, n, e;
    } ent_t;
    logic clk = 0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    ent_t q[$];
    logic [15:0] m_cnt = 0;
    alu_bitwise_stage_if #(.WIDTH(W)) bus ();
    alu_bitwise_stage #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic ent_t ref_model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        ent_t x;
        x.e = 0;
        case (op)
            0: x.r = a & b;
            1: x.r = a | b;
            2: x.r = a ^ b;
            3: x.r = ~(a | b);
            default: begin x.r = 0; x.e = 1; end
        endcase
        x.z = (x.r == 0);
        x.n = x.r[W-1];
        return x;
    endfunction
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_all();
        ent_t h;
        h = q.size() > 0 ? q[0] : '{r: 0, z: 0, n: 0, e: 0};
        chk("o_valid", W'(bus.o_valid), W'(q.size() > 0));
        chk("o_ready", W'(bus.o_ready), W'(q.size() < D));
        chk("o", bus.o, h.r);
        chk("o_zero", W'(bus.o_zero), W'(h.z));
        chk("o_neg", W'(bus.o_neg), W'(h.n));
        chk("o_err", W'(bus.o_err), W'(h.e));
        chk("o_count", W'(bus.o_count), W'(m_cnt));
    endtask
    task automatic step(input logic r, input logic v, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic rd);
        bit acc, pop;
        rst = r; bus.i_valid = v; bus.i_op = op; bus.i_1 = a; bus.i_2 = b; bus.i_ready = rd;
        acc = v && q.size() < D;
        pop = rd && q.size() > 0;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_model(int'(op), a, b));
                m_cnt++;
            end
        end
        #1;
        check_all();
    endtask
    task automatic rnd_step(input logic r, input logic v, input logic rd);
        step(r, v, 3'($urandom_range(0, 7)), $urandom, $urandom, rd);
    endtask
    initial begin
        rst = 1; bus.i_valid = 0; bus.i_op = 0; bus.i_1 = 0; bus.i_2 = 0; bus.i_ready = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("reset_ready", W'(bus.o_ready), W'(1));
        step(0, 1, 3'd1, 32'h0000_129F, 32'h0000_0BD2, 1);
        chk("or_result", bus.o, 32'h0000_1BDF);
        chk("or_count", W'(bus.o_count), W'(1));
        step(0, 1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        chk("nor_zero", W'(bus.o_zero), W'(1));
        step(0, 1, 3'd2, 32'h8000_0000, 32'h0, 1);
        chk("xor_neg", W'(bus.o_neg), W'(1));
        step(0, 1, 3'd5, $urandom, $urandom, 1);
        chk("illegal_err", W'(bus.o_err), W'(1));
        step(0, 1, 3'd0, $urandom, $urandom, 1);
        chk("legal_err", W'(bus.o_err), W'(0));
        step(0, 0, 0, 0, 0, 1);
        // backpressure: third request waits until a pop frees space
        step(1, 0, 0, 0, 0, 0);
        rnd_step(0, 1, 0);
        rnd_step(0, 1, 0);
        chk("full_ready", W'(bus.o_ready), W'(0));
        rnd_step(0, 1, 0);
        rnd_step(0, 1, 0);
        rnd_step(0, 1, 1);
        rnd_step(0, 1, 1);
        rnd_step(0, 0, 1);
        rnd_step(0, 0, 1);
        chk("bp_count", W'(bus.o_count), W'(3));
        chk("bp_drained", W'(bus.o_valid), W'(0));
        rnd_step(0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            rnd_step(0, 1, 1);
            chk("stream_valid", W'(bus.o_valid), W'(1));
        end
        rnd_step(0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) rnd_step(0, 1, 1);
        rnd_step(0, 1, 0);
        chk("pre_rst_count", W'(bus.o_count), W'(7));
        chk("pre_rst_full", W'(bus.o_ready), W'(0));
        rnd_step(1, 1, 1);
        chk("rst_count", W'(bus.o_count), W'(0));
        chk("rst_valid", W'(bus.o_valid), W'(0));
        rnd_step(0, 0, 0);
        chk("rst_no_entry", W'(bus.o_valid), W'(0));
        for (int i = 0; i < 400; i++)
            rnd_step($urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 2) != 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_bitwise_stage.md
ALU_BITWISE_STAGE -- requirements
Module: alu_bitwise_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, result-buffer entries; legal values 2 to 8.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  upstream request valid.
REQ-006 o_ready  output  1  block can accept a request this cycle.
REQ-007 i_op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOR, 4-7 illegal.
REQ-008 i_1, i_2  input  WIDTH each  operands.
REQ-009 o_valid  output  1  result entry at buffer head valid.
REQ-010 i_ready  input  1  downstream accepts head entry.
REQ-011 o  output  WIDTH  head result.
REQ-012 o_zero, o_neg, o_err  output  1 each  head flags: result all-zero, result MSB, illegal opcode.
REQ-013 o_count  output  16  number of requests accepted since reset.

Function
REQ-014 Accept SHALL occur on a cycle with i_valid and o_ready both high; pop SHALL occur on a cycle with o_valid and i_ready both high.
REQ-015 The result of an accepted request SHALL be computed combinationally from i_1, i_2, i_op and written into the buffer at that edge.
REQ-016 An accepted request into an empty buffer SHALL appear on o/o_valid exactly one cycle later (latency 1); no combinational path SHALL exist from inputs to o, o_valid or flags.
REQ-017 Illegal opcode SHALL store result 0, o_err 1, o_zero 1, o_neg 0; legal opcodes SHALL store o_err 0.
REQ-018 o_zero SHALL be 1 iff the stored result equals 0; o_neg SHALL equal stored result bit WIDTH-1.
REQ-019 The buffer SHALL be a FIFO of DEPTH entries, each holding result plus three flags, preserving acceptance order.
REQ-020 o_ready SHALL be high iff occupancy < DEPTH (registered-state function only; no dependence on i_ready).
REQ-021 o_valid SHALL be high iff occupancy > 0.
REQ-022 Simultaneous accept and pop SHALL leave occupancy unchanged and preserve order, including at occupancy DEPTH-1.
REQ-023 At occupancy DEPTH, i_valid SHALL be ignored and no state SHALL change except via pop.
REQ-024 At occupancy 0, i_ready SHALL be ignored.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 o_count SHALL increment by 1 per accept, wrap from 65535 to 0, and SHALL NOT count pops.
REQ-027 o, o_zero, o_neg, o_err SHALL hold their values while o_valid is high and i_ready is low.

Reset
REQ-028 On a clock edge with rst high: occupancy 0, pointers 0, o_count 0, o_valid 0, o_ready 1 after that edge.
REQ-029 Reset SHALL discard buffered entries and any same-cycle accept or pop.
REQ-030 While o_valid is 0, o and flags SHALL read 0.
REQ-031 Reset SHALL take priority over all other events.

Structure
REQ-032 A shared package alu_pkg SHALL hold the opcode enumeration (OP_AND, OP_OR, OP_XOR, OP_NOR) and the constant ALU_WIDTH = 32.
REQ-033 The OR path SHALL reuse the existing or_bitwise module; AND/XOR/NOR are inline.
REQ-034 The FIFO SHALL be one sub-module, alu_res_fifo, parameterised by data width and DEPTH.
REQ-035 RTL target 120-400 lines total.

Verification
REQ-036 Reset, then i_op=1, i_1=32'h0000_129F, i_2=32'h0000_0BD2, one-cycle valid, i_ready=1 -> next cycle o_valid=1, o=32'h0000_1BDF, o_zero=0, o_neg=0, o_count=1.
REQ-037 i_op=3, i_1=i_2=32'hFFFF_FFFF -> o=0, o_zero=1, o_neg=0; i_op=2 with i_1=32'h8000_0000, i_2=0 -> o_neg=1.
REQ-038 i_ready=0, three back-to-back requests (DEPTH=2) -> o_ready low after second accept, third held; then i_ready=1 -> results pop in order, third accepted, o_count=3.
REQ-039 Occupancy 1 with i_valid and i_ready both high for 10 cycles -> occupancy stays 1, 10 results in order, no loss.
REQ-040 i_op=5 -> o=0, o_err=1, o_zero=1; next legal request -> o_err=0.
REQ-041 Occupancy 2 and o_count=7, assert rst one cycle with i_valid high -> o_valid=0, o_ready=1, o_count=0, no entry stored.
